// File: rtl/seg_scan_pkg.sv
//==============================================================================
// Module   : seg_scan_pkg
// Brief    : Shared types and helpers for the seven-segment scan scheduler.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package seg_scan_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // All anodes released (active-low display)
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Index of one of the four display digits
  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode vector selecting digit idx
  function automatic logic [3:0] onehot_low(input digit_idx_t idx);
    logic [3:0] v;
    v      = ANODE_OFF;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_slot_timer.sv
//==============================================================================
// Module   : scan_slot_timer
// Brief    : Slot counter for the scan scheduler. Counts 0..2^DIVIDE_BY-1 per
//            digit slot and flags the end of the blank and drive windows.
//            Held at zero whenever run is low.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module scan_slot_timer #(
  parameter int DIVIDE_BY    = 17,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic blank_end,
  output logic drive_end
);

  localparam logic [DIVIDE_BY-1:0] BLANK_LAST = DIVIDE_BY'(BLANK_CYCLES - 1);
  localparam logic [DIVIDE_BY-1:0] ONE        = DIVIDE_BY'(1);

  logic [DIVIDE_BY-1:0] count;

  // Free-running slot count; wraps naturally at the end of each slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign blank_end = (count == BLANK_LAST);
  assign drive_end = &count;

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
//==============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed scan scheduler for a 4-digit seven-segment
//            display. Double-buffered 16-bit word load over valid/ready,
//            blank/drive windows per digit, registered active-low anodes.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros
//            on digits 3..1.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int DIVIDE_BY    = 17,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic [1:0]  digit_idx,
  output logic        blank,
  output logic        frame_done
);

  import seg_scan_pkg::*;

  scan_state_t state;
  digit_idx_t  idx;
  logic [15:0] active;
  logic [15:0] shadow;
  logic        shadow_full;
  logic        run;
  logic        blank_end;
  logic        drive_end;
  logic        hide;

  // Counter only advances once the scan has left OFF
  assign run = enable && (state != OFF);

  scan_slot_timer #(
    .DIVIDE_BY    (DIVIDE_BY),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .blank_end (blank_end),
    .drive_end (drive_end)
  );

  assign frame_done = (state == DRIVE) && drive_end && (idx == 2'd3);
  assign load_ready = !shadow_full;
  assign digit_idx  = idx;

  // Decide whether the upcoming drive slot is a suppressed leading zero
  always_comb begin
    hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    hide = (active[15:12] == 4'h0);
      2'd2:    hide = (active[15:8]  == 8'h0);
      2'd1:    hide = (active[15:4]  == 12'h0);
      default: hide = 1'b0;
    endcase
`endif
  end

  // Scan FSM with registered anode/digit/blank outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OFF;
      idx   <= '0;
      an    <= ANODE_OFF;
      digit <= '0;
      blank <= 1'b1;
    end else if (!enable) begin
      state <= OFF;
      idx   <= '0;
      an    <= ANODE_OFF;
      blank <= 1'b1;
    end else begin
      case (state)
        OFF: begin
          state <= BLANK;
        end
        BLANK: begin
          if (blank_end) begin
            state <= DRIVE;
            digit <= active[{idx, 2'b00} +: 4];
            an    <= hide ? ANODE_OFF : onehot_low(idx);
            blank <= hide;
          end
        end
        DRIVE: begin
          if (drive_end) begin
            state <= BLANK;
            idx   <= idx + 2'd1;
            an    <= ANODE_OFF;
            blank <= 1'b1;
          end
        end
        default: begin
          state <= OFF;
        end
      endcase
    end
  end

  // Double buffer: shadow takes loads, active only changes at a frame
  // boundary or while the display is off so a frame never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
    end else if (shadow_full && (frame_done || (state == OFF))) begin
      active      <= shadow;
      shadow_full <= 1'b0;
    end else if (load_valid && !shadow_full) begin
      shadow      <= load_data;
      shadow_full <= 1'b1;
    end
  end

endmodule

`default_nettype wire
